// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared constants and types for the data-memory / MMIO block.
//   MMIO_BIT      : address bit that selects MMIO space (1) versus data RAM (0)
//   OFF_*         : MMIO word offsets, taken from address bits [4:2]
//   uart_state_t  : state encoding of the UART transmitter
// Related build macro: DMEM_UART_EN (enables the UART in dmem_mmio).
package dmem_pkg;

  localparam int MMIO_BIT = 10;

  localparam logic [2:0] OFF_LED    = 3'd0;  // 0x400 read/write LED register
  localparam logic [2:0] OFF_SW     = 3'd1;  // 0x404 synchronized switches, read-only
  localparam logic [2:0] OFF_TIMER  = 3'd2;  // 0x408 free-running cycle counter
  localparam logic [2:0] OFF_UARTTX = 3'd3;  // 0x40C UART transmit data, write-only
  localparam logic [2:0] OFF_STATUS = 3'd4;  // 0x410 UART busy flag, read-only

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx.sv
// uart_tx -- 8N1 UART transmitter.
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-low reset; forces the line high and the FSM to idle
//   start  : accepted only while idle; latches data and begins a frame next cycle
//   data   : byte to send, LSB first
//   tx     : serial output, idles high
//   busy   : high in every state except idle
// Instantiated by dmem_mmio only when DMEM_UART_EN is defined.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);
  import dmem_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg;
  logic          bit_done;

  assign bit_done = (cnt_reg == CNT_LAST);

  // tx is registered so the line only changes on state transitions; it is
  // part of the async reset so an aborted frame releases the line at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= UART_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      case (state_reg)
        UART_IDLE: begin
          cnt_reg <= '0;
          tx_reg  <= 1'b1;
          if (start) begin
            state_reg <= UART_START;
            shift_reg <= data;
            tx_reg    <= 1'b0;
          end
        end
        UART_START: begin
          cnt_reg <= bit_done ? '0 : cnt_reg + 1'b1;
          if (bit_done) begin
            state_reg <= UART_DATA;
            bit_reg   <= '0;
            tx_reg    <= shift_reg[0];
          end
        end
        UART_DATA: begin
          cnt_reg <= bit_done ? '0 : cnt_reg + 1'b1;
          if (bit_done) begin
            if (bit_reg == 3'd7) begin
              state_reg <= UART_STOP;
              tx_reg    <= 1'b1;
            end else begin
              // Shift first and present the next bit from the pre-shift copy.
              bit_reg   <= bit_reg + 1'b1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx_reg    <= shift_reg[1];
            end
          end
        end
        UART_STOP: begin
          cnt_reg <= bit_done ? '0 : cnt_reg + 1'b1;
          if (bit_done) begin
            state_reg <= UART_IDLE;
          end
        end
        default: begin
          state_reg <= UART_IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign tx   = tx_reg;
  assign busy = (state_reg != UART_IDLE);

endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio -- pipeline data memory with a small memory-mapped I/O block.
// Ports:
//   clk, reset  : system clock, asynchronous active-low reset
//   MemWriteM   : store strobe
//   ALUOutM     : byte address (bits [1:0] ignored); bit 10 selects MMIO
//   WriteDataM  : store data
//   ReadDataM   : combinational load data for ALUOutM
//   sw          : asynchronous switches, synchronized before being read
//   led         : LED register (MMIO 0x400)
//   tx          : UART serial output, idles high
// Map: 0x400 LED, 0x404 SW, 0x408 TIMER, 0x40C UARTTX, 0x410 STATUS,
// 0x414-0x41C read 0. Define DMEM_UART_EN to build the UART; without it tx
// is held high and 0x40C/0x410 behave as unmapped.
module dmem_mmio #(
  parameter int RAM_WORDS    = 64,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  input  logic [7:0]  sw,
  output logic [7:0]  led,
  output logic        tx
);
  import dmem_pkg::*;

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic          ram_sel;
  logic [AW-1:0] ram_idx;
  logic [2:0]    mmio_off;
  logic          mmio_we;
  logic [31:0]   ram_rdata;
  logic [31:0]   mmio_rdata;

  logic [7:0]    led_reg;
  logic [31:0]   timer_reg;
  logic [7:0]    sw_meta_reg;
  logic [7:0]    sw_sync_reg;

  assign ram_sel  = ~ALUOutM[MMIO_BIT];
  assign ram_idx  = ALUOutM[2 +: AW];
  assign mmio_off = ALUOutM[4:2];
  assign mmio_we  = MemWriteM & ALUOutM[MMIO_BIT];

  // Address bits outside the decoded fields alias onto the same locations.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ALUOutM[31:11], ALUOutM[9:5], ALUOutM[1:0]};

  // Data RAM: write on the edge, asynchronous read so a load straight after
  // a store sees the new word. Contents are deliberately left out of reset.
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (MemWriteM && ram_sel) begin
      ram[ram_idx] <= WriteDataM;
    end
  end

  assign ram_rdata = ram[ram_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_reg     <= '0;
      timer_reg   <= '0;
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= sw;
      sw_sync_reg <= sw_meta_reg;
      if (mmio_we && (mmio_off == OFF_LED)) begin
        led_reg <= WriteDataM[7:0];
      end
      // A software load wins over the increment for that one cycle.
      if (mmio_we && (mmio_off == OFF_TIMER)) begin
        timer_reg <= WriteDataM;
      end else begin
        timer_reg <= timer_reg + 32'd1;
      end
    end
  end

  assign led = led_reg;

`ifdef DMEM_UART_EN
  logic uart_busy;
  logic uart_start;

  // Writes that arrive while a frame is in flight are dropped, not queued.
  assign uart_start = mmio_we && (mmio_off == OFF_UARTTX) && !uart_busy;

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .reset(reset),
    .start(uart_start),
    .data (WriteDataM[7:0]),
    .tx   (tx),
    .busy (uart_busy)
  );
`else
  localparam int unused_clks_per_bit = CLKS_PER_BIT;
  assign tx = 1'b1;
`endif

  always_comb begin
    mmio_rdata = '0;
    case (mmio_off)
      OFF_LED:    mmio_rdata = {24'b0, led_reg};
      OFF_SW:     mmio_rdata = {24'b0, sw_sync_reg};
      OFF_TIMER:  mmio_rdata = timer_reg;
`ifdef DMEM_UART_EN
      OFF_STATUS: mmio_rdata = {31'b0, uart_busy};
`endif
      default:    mmio_rdata = '0;
    endcase
  end

  assign ReadDataM = ram_sel ? ram_rdata : mmio_rdata;

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio -- self-checking bench for dmem_mmio (RAM_WORDS=64,
// CLKS_PER_BIT=4). Expected values come from a behavioural model: a word
// array for RAM, a shadow LED byte, a timer expressed as "last loaded value
// plus cycles elapsed", and a UART frame built from the 8N1 bit layout.
// UART checks follow the DMEM_UART_EN build option.
module tb_dmem_mmio;

  localparam int RW  = 64;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUOutM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic [7:0]  sw = '0;
  logic [7:0]  led;
  logic        tx;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  logic [31:0] ram_m [RW];
  logic [7:0]  led_m = '0;
  logic [31:0] timer_base = '0;
  int unsigned timer_cyc = 0;

  dmem_mmio #(
    .RAM_WORDS   (RW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWriteM (MemWriteM),
    .ALUOutM   (ALUOutM),
    .WriteDataM(WriteDataM),
    .ReadDataM (ReadDataM),
    .sw        (sw),
    .led       (led),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] timer_exp();
    return timer_base + 32'(cyc - timer_cyc);
  endfunction

  // Level of the serial line k cycles after the frame began: one start bit,
  // eight data bits LSB first, one stop bit, each CPB cycles long.
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ALUOutM    = a;
    WriteDataM = d;
    MemWriteM  = 1'b1;
    tick();
    MemWriteM  = 1'b0;
    if (a[10] == 1'b0) begin
      ram_m[(a >> 2) % RW] = d;
    end else if (a[4:2] == 3'd0) begin
      led_m = d[7:0];
    end else if (a[4:2] == 3'd2) begin
      timer_base = d;
      timer_cyc  = cyc;
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] expv, input string tag);
    ALUOutM   = a;
    MemWriteM = 1'b0;
    #1;
    check(tag, ReadDataM, expv);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  sw_old;
    logic [7:0]  sw_vals [3];

    // Reset state
    @(negedge clk);
    #1;
    check("rst_led", {24'b0, led}, 32'h0);
    check("rst_tx", {31'b0, tx}, 32'h1);
    rd(32'h400, 32'h0, "rst_rd_led");
    rd(32'h404, 32'h0, "rst_rd_sw");
    rd(32'h408, 32'h0, "rst_rd_timer");
    rd(32'h410, 32'h0, "rst_rd_status");
    @(negedge clk);
    reset      = 1'b1;
    timer_base = '0;
    timer_cyc  = cyc;

    tick();
    rd(32'h408, timer_exp(), "timer_first");

    // Store then load, with the low byte-offset bits ignored
    wr(32'h20, 32'hDEADBEEF);
    rd(32'h20, 32'hDEADBEEF, "ram_20");
    rd(32'h23, 32'hDEADBEEF, "ram_23");

    // Fill every word through aliased addresses (random upper and low bits)
    for (int i = 0; i < RW; i++) begin
      a = ($urandom & 32'hFFFF_FB03) | (32'(i) << 2);
      wr(a, $urandom);
    end
    for (int i = 0; i < RW; i += 9) begin
      rd(32'(i) << 2, ram_m[i], "ram_fill");
    end

    // Randomized mix of RAM, LED and timer traffic
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = $urandom & 32'hFFFF_FBFF;
          d = $urandom;
          wr(a, d);
          rd(a, d, "rand_store_load");
        end
        1: begin
          a = $urandom & 32'hFFFF_FBFF;
          rd(a, ram_m[(a >> 2) % RW], "rand_load");
        end
        2: begin
          wr(32'h400, $urandom);
          check("rand_led", {24'b0, led}, {24'b0, led_m});
        end
        default: begin
          tick();
          rd(32'h408, timer_exp(), "rand_timer");
        end
      endcase
    end

    // LED register
    wr(32'h400, 32'h1A5);
    check("led_out", {24'b0, led}, 32'hA5);
    rd(32'h400, 32'h000000A5, "led_rd");
    wr(32'h404, 32'hFF);
    rd(32'h404, 32'h0, "sw_wr_ignored");
    check("led_hold", {24'b0, led}, 32'hA5);

    // Unmapped offsets read 0 and leave LED alone
    for (int off = 5; off < 8; off++) begin
      wr(32'h400 | (32'(off) << 2), $urandom);
      rd(32'h400 | (32'(off) << 2), 32'h0, "unmapped");
    end
    check("led_after_unmapped", {24'b0, led}, {24'b0, led_m});

    // Timer load and wrap
    wr(32'h408, 32'hFFFFFFFE);
    rd(32'h408, 32'hFFFFFFFE, "timer_load");
    tick();
    rd(32'h408, 32'hFFFFFFFF, "timer_ff");
    tick();
    rd(32'h408, 32'h00000000, "timer_wrap");
    tick();
    rd(32'h408, timer_exp(), "timer_model");

    // Switch synchronizer: visible only after the second edge
    sw_vals[0] = 8'h3C;
    sw_vals[1] = 8'($urandom);
    sw_vals[2] = ~sw_vals[1];
    sw_old = 8'h00;
    for (int i = 0; i < 3; i++) begin
      sw = sw_vals[i];
      rd(32'h404, {24'b0, sw_old}, "sw_edge0");
      tick();
      rd(32'h404, {24'b0, sw_old}, "sw_edge1");
      tick();
      rd(32'h404, {24'b0, sw_vals[i]}, "sw_edge2");
      sw_old = sw_vals[i];
    end

`ifdef DMEM_UART_EN
    // Frame for 0x55, with a dropped write while busy
    wr(32'h40C, 32'h55);
    for (int k = 0; k < 10 * CPB; k++) begin
      check("uart_tx", {31'b0, tx}, {31'b0, frame_bit(8'h55, k)});
      rd(32'h410, 32'h1, "uart_busy");
      if (k == 5) wr(32'h40C, 32'h0F);
      else tick();
    end
    check("uart_idle_tx", {31'b0, tx}, 32'h1);
    rd(32'h410, 32'h0, "uart_idle_busy");
    rd(32'h40C, 32'h0, "uart_rd_zero");
    // Write in the idle cycle right after stop: new frame back-to-back
    wr(32'h40C, 32'hA3);
    for (int k = 0; k < 6; k++) begin
      check("uart_b2b_tx", {31'b0, tx}, {31'b0, frame_bit(8'hA3, k)});
      rd(32'h410, 32'h1, "uart_b2b_busy");
      tick();
    end
`else
    wr(32'h40C, 32'h55);
    check("nouart_tx", {31'b0, tx}, 32'h1);
    rd(32'h40C, 32'h0, "nouart_rd_tx");
    wr(32'h410, 32'h1);
    rd(32'h410, 32'h0, "nouart_rd_status");
    for (int k = 0; k < 6; k++) begin
      tick();
      check("nouart_tx_idle", {31'b0, tx}, 32'h1);
    end
`endif

    // Reset mid-frame: outputs clear at once, RAM keeps its contents
    #1;
    reset = 1'b0;
    #1;
    check("midrst_tx", {31'b0, tx}, 32'h1);
    check("midrst_led", {24'b0, led}, 32'h0);
    rd(32'h410, 32'h0, "midrst_busy");
    rd(32'h408, 32'h0, "midrst_timer");
    rd(32'h400, 32'h0, "midrst_rd_led");
    rd(32'h20, ram_m[8], "midrst_ram");
    @(negedge clk);
    reset      = 1'b1;
    led_m      = '0;
    timer_base = '0;
    timer_cyc  = cyc;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_tx", {31'b0, tx}, 32'h1);
      rd(32'h408, timer_exp(), "post_rst_timer");
      rd(32'h410, 32'h0, "post_rst_busy");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
- REQ-001: Parameter RAM_WORDS, default 64; number of 32-bit data RAM words (power of two, at most 256).
- REQ-002: Parameter CLKS_PER_BIT, default 434; UART bit period in clk cycles (at least 2).
- REQ-003: clk  input  1  single system clock; all state updates on its rising edge.
- REQ-004: reset  input  1  asynchronous, active-low reset (asserted when 0).
- REQ-005: MemWriteM  input  1  store strobe from the pipeline memory stage.
- REQ-006: ALUOutM  input  32  byte address; bits [1:0] ignored (word access only).
- REQ-007: WriteDataM  input  32  store data.
- REQ-008: ReadDataM  output  32  load data, combinational from ALUOutM in the same cycle.
- REQ-009: sw  input  8  asynchronous board switches.
- REQ-010: led  output  8  LED register.
- REQ-011: tx  output  1  UART serial output; idles high.

Function
- REQ-012: Address decode SHALL be: ALUOutM[10]=0 selects RAM word ALUOutM[2+:log2(RAM_WORDS)], with higher address bits ignored; ALUOutM[10]=1 selects MMIO offset ALUOutM[4:2].
- REQ-013: RAM SHALL be written at the clock edge when MemWriteM=1 and RAM is selected; reads SHALL be combinational, so a load after a store returns the new data.
- REQ-014: MMIO 0x400 LED SHALL be read/write; a write stores WriteDataM[7:0] into led; a read returns {24'b0,led}.
- REQ-015: MMIO 0x404 SW SHALL be read-only; the read returns {24'b0,sw_sync}, where sw_sync is sw after a 2-flop synchronizer (2-cycle latency); writes are ignored.
- REQ-016: MMIO 0x408 TIMER SHALL be a 32-bit counter that increments every cycle and wraps from 0xFFFFFFFF to 0; a write loads WriteDataM and takes priority over the increment; the counter resumes counting from the loaded value on the next cycle.
- REQ-017: MMIO 0x40C UARTTX: a write while the UART is idle SHALL latch WriteDataM[7:0] and start a frame on the next cycle; a write while busy SHALL be dropped; the read value is 0.
- REQ-018: MMIO 0x410 STATUS SHALL read {31'b0,busy} and be read-only.
- REQ-019: Unmapped MMIO offsets (0x414–0x41C) SHALL read 0 and ignore writes.
- REQ-020: The UART FSM SHALL have the states IDLE, START, DATA, STOP.
  - IDLE→START on an accepted write.
  - START drives 0 for CLKS_PER_BIT cycles.
  - DATA sends 8 bits, LSB first, each for CLKS_PER_BIT cycles.
  - STOP drives 1 for CLKS_PER_BIT cycles, then →IDLE.
  - busy=1 in every state except IDLE.
- REQ-021: A write accepted in the IDLE cycle that immediately follows STOP SHALL begin a new frame back-to-back.

Reset
- REQ-022: While reset=0: led=0, tx=1, timer=0, UART=IDLE, busy=0, synchronizer flops=0.
- REQ-023: RAM contents SHALL NOT be reset.
- REQ-024: Reset asserted mid-frame SHALL abort the frame immediately, with tx=1 asynchronously.

Configuration
- REQ-025: Macro DMEM_UART_EN.
  - When defined: the UART per REQ-017, REQ-018, REQ-020 and REQ-021 is present.
  - When undefined: no UART logic exists; tx is tied to 1; 0x40C and 0x410 read 0 and ignore writes.

Structure
- REQ-026: Package dmem_pkg SHALL hold the MMIO offset constants, the MMIO base bit index (10) and the uart_state_t enum.
- REQ-027: The UART SHALL be a sub-module uart_tx (ports clk, reset, start, data[7:0], tx, busy), instantiated only under DMEM_UART_EN.

Verification
- REQ-028: The bench SHALL cover these scenarios:
  - Store 0xDEADBEEF to 0x20, then load 0x20 → ReadDataM=0xDEADBEEF; load 0x23 → same value.
  - Write 0x1A5 to 0x400 → led=0xA5; read 0x400 → 0x000000A5.
  - Write 0xFFFFFFFE to 0x408, then read on the next cycles → 0xFFFFFFFF, then 0x00000000.
  - With CLKS_PER_BIT=4, write 0x55 to 0x40C → tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; a second write of 0x0F while busy is dropped; 0x410 reads 1 during the frame and 0 after.
  - Set sw=0x3C → 0x404 reads 0x3C only from the 2nd clock edge onward.
  - Drive reset=0 mid-frame → tx=1 and busy=0 at once; led=0; timer=0.
